// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: per-stage stall requests and MEM-stage redirects in,
// merged stall vector, flush/redirect and stall accounting out.
interface pipe_ctrl_if;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        except_req;
   logic [31:0] except_vec;
   logic        eret_req;
   logic [31:0] epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] stall_cycles;
   logic        stall_timeout;

   modport master (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output except_req, except_vec, eret_req, epc,
      input  stall, flush, new_pc, stall_cycles, stall_timeout
   );

   modport slave (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  except_req, except_vec, eret_req, epc,
      output stall, flush, new_pc, stall_cycles, stall_timeout
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge (0-cycle), redirect flush/settle FSM (flush 1 cycle after request), stall accounting.
// No backpressure: redirects arriving in FLUSH/SETTLE are dropped; PIPE_CTRL_WDOG_EN adds the stall watchdog.
module pipe_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int STALL_LIMIT   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  pif
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || STALL_LIMIT < 2 || STALL_LIMIT > 65535) begin : g_bad_param
      $error("pipe_ctrl: parameter out of range");
   end

   typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, SETTLE = 2'd2} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  settle_cnt;
   logic        flush_r;
   logic [31:0] new_pc_r;
   logic [31:0] stall_cycles_r;
   logic [5:0]  stall_c;
   logic        redirect;

   assign redirect = (state == RUN) && (pif.except_req || pif.eret_req);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RUN;
         settle_cnt <= '0;
         flush_r    <= 1'b0;
         new_pc_r   <= '0;
      end else begin
         state   <= state_nxt;
         flush_r <= (state_nxt == FLUSH);
         if (redirect)
            new_pc_r <= pif.except_req ? pif.except_vec : pif.epc;
         if (state == FLUSH)
            settle_cnt <= 4'(SETTLE_CYCLES - 1);
         else if (state == SETTLE && settle_cnt != 4'd0)
            settle_cnt <= settle_cnt - 4'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (pif.except_req || pif.eret_req) state_nxt = FLUSH;
         FLUSH:   state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == 4'd0) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Highest requesting stage freezes itself and everything upstream; WB never holds.
   always_comb begin
      stall_c = 6'b000000;
      if (rst && state != FLUSH) begin
         if (pif.stallreq_mem)      stall_c = 6'b011111;
         else if (pif.stallreq_ex)  stall_c = 6'b001111;
         else if (pif.stallreq_id)  stall_c = 6'b000111;
         else if (pif.stallreq_if)  stall_c = 6'b000011;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cycles_r <= '0;
      else if (stall_c != 6'b000000 && stall_cycles_r != 32'hFFFF_FFFF)
         stall_cycles_r <= stall_cycles_r + 32'd1;
   end

   assign pif.stall        = stall_c;
   assign pif.flush        = flush_r;
   assign pif.new_pc       = new_pc_r;
   assign pif.stall_cycles = stall_cycles_r;

`ifdef PIPE_CTRL_WDOG_EN
   logic [15:0] wdog_cnt;
   logic        timeout_r;

   // Counter saturates at the limit; the flag is raised on the edge that reaches it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_cnt  <= '0;
         timeout_r <= 1'b0;
      end else if (stall_c != 6'b000000) begin
         if (wdog_cnt != 16'(STALL_LIMIT))
            wdog_cnt <= wdog_cnt + 16'd1;
         if (wdog_cnt == 16'(STALL_LIMIT - 1))
            timeout_r <= 1'b1;
      end else begin
         wdog_cnt <= '0;
      end
   end

   assign pif.stall_timeout = timeout_r;
`else
   assign pif.stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (SETTLE_CYCLES=2, STALL_LIMIT=8); watchdog
// expectations follow whether PIPE_CTRL_WDOG_EN is defined.
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_if pif ();

   pipe_ctrl #(.SETTLE_CYCLES(2), .STALL_LIMIT(8)) dut (
      .clk (clk),
      .rst (rst),
      .pif (pif)
   );

`ifdef PIPE_CTRL_WDOG_EN
   localparam logic [31:0] WDOG = 32'd1;
`else
   localparam logic [31:0] WDOG = 32'd0;
`endif

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_sc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      pif.stallreq_if  = 1'b0;
      pif.stallreq_id  = 1'b0;
      pif.stallreq_ex  = 1'b0;
      pif.stallreq_mem = 1'b0;
      pif.except_req   = 1'b0;
      pif.eret_req     = 1'b0;
   endtask

   initial begin
      clear_reqs();
      pif.except_vec   = 32'h0;
      pif.epc          = 32'h0;
      pif.stallreq_mem = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", 32'(pif.stall), 32'h0);
      check("rst_flush", 32'(pif.flush), 32'h0);
      check("rst_new_pc", pif.new_pc, 32'h0);
      check("rst_stall_cycles", pif.stall_cycles, 32'h0);
      check("rst_timeout", 32'(pif.stall_timeout), 32'h0);
      pif.stallreq_mem = 1'b0;
      rst = 1'b1;
      tick();
      exp_sc = 32'd0;

      // stall priority, all combinational within one cycle
      pif.stallreq_id = 1'b1;
      #1 check("stall_id", 32'(pif.stall), 32'h07);
      pif.stallreq_mem = 1'b1;
      #1 check("stall_id_mem", 32'(pif.stall), 32'h1F);
      pif.stallreq_mem = 1'b0;
      pif.stallreq_id  = 1'b0;
      pif.stallreq_if  = 1'b1;
      #1 check("stall_if", 32'(pif.stall), 32'h03);
      pif.stallreq_if = 1'b0;
      pif.stallreq_ex = 1'b1;
      #1 check("stall_ex", 32'(pif.stall), 32'h0F);
      pif.stallreq_ex = 1'b0;
      #1 check("stall_release", 32'(pif.stall), 32'h00);
      tick();
      check("sc_idle", pif.stall_cycles, exp_sc);

      // watchdog: 7 cycles below limit, break, then 8 consecutive
      pif.stallreq_mem = 1'b1;
      repeat (7) tick();
      exp_sc += 7;
      check("wdog_7", 32'(pif.stall_timeout), 32'h0);
      pif.stallreq_mem = 1'b0;
      tick();
      pif.stallreq_mem = 1'b1;
      repeat (8) tick();
      exp_sc += 8;
      check("wdog_8", 32'(pif.stall_timeout), WDOG);
      pif.stallreq_mem = 1'b0;
      tick();
      check("wdog_sticky", 32'(pif.stall_timeout), WDOG);
      check("sc_wdog", pif.stall_cycles, exp_sc);

      // stall accounting
      pif.stallreq_ex = 1'b1;
      repeat (10) tick();
      pif.stallreq_ex = 1'b0;
      exp_sc += 10;
      check("sc_ex10", pif.stall_cycles, exp_sc);
      tick();
      check("sc_hold", pif.stall_cycles, exp_sc);

      // exception while EX stalls; stall masked in FLUSH, back in SETTLE
      pif.except_req  = 1'b1;
      pif.except_vec  = 32'hBFC0_0380;
      pif.stallreq_ex = 1'b1;
      tick();
      exp_sc += 1;
      pif.except_req = 1'b0;
      check("exc_flush", 32'(pif.flush), 32'h1);
      check("exc_new_pc", pif.new_pc, 32'hBFC0_0380);
      check("exc_stall_masked", 32'(pif.stall), 32'h0);
      tick();
      check("exc_flush_1cyc", 32'(pif.flush), 32'h0);
      check("settle_stall", 32'(pif.stall), 32'h0F);
      check("sc_flush_masked", pif.stall_cycles, exp_sc);
      pif.stallreq_ex = 1'b0;
      pif.except_req  = 1'b1;
      pif.except_vec  = 32'h1111_0000;
      tick();
      check("settle_drop1", 32'(pif.flush), 32'h0);
      tick();
      check("settle_drop2", 32'(pif.flush), 32'h0);
      tick();
      check("run_reentry", 32'(pif.flush), 32'h1);
      check("run_reentry_pc", pif.new_pc, 32'h1111_0000);
      pif.except_req = 1'b0;
      repeat (3) tick();

      // simultaneous exception and ERET; exception wins
      pif.except_req = 1'b1;
      pif.except_vec = 32'h8000_0180;
      pif.eret_req   = 1'b1;
      pif.epc        = 32'h0000_0040;
      tick();
      clear_reqs();
      check("both_flush", 32'(pif.flush), 32'h1);
      check("both_new_pc", pif.new_pc, 32'h8000_0180);
      tick();
      pif.except_req = 1'b1;
      pif.except_vec = 32'hDEAD_0000;
      tick();
      check("settle_ignore", 32'(pif.flush), 32'h0);
      check("new_pc_hold", pif.new_pc, 32'h8000_0180);
      pif.except_req = 1'b0;
      tick();
      check("settle_no_flush", 32'(pif.flush), 32'h0);

      // ERET then reset in SETTLE
      pif.eret_req = 1'b1;
      pif.epc      = 32'h0000_0200;
      tick();
      pif.eret_req = 1'b0;
      check("eret_flush", 32'(pif.flush), 32'h1);
      check("eret_new_pc", pif.new_pc, 32'h0000_0200);
      tick();
      pif.stallreq_id = 1'b1;
      rst = 1'b0;
      #1;
      check("rst_mid_flush", 32'(pif.flush), 32'h0);
      check("rst_mid_stall", 32'(pif.stall), 32'h0);
      check("rst_mid_new_pc", pif.new_pc, 32'h0);
      check("rst_mid_sc", pif.stall_cycles, 32'h0);
      tick();
      rst = 1'b1;
      pif.stallreq_id = 1'b0;
      pif.eret_req    = 1'b1;
      pif.epc         = 32'h0000_1000;
      tick();
      pif.eret_req = 1'b0;
      check("post_rst_flush", 32'(pif.flush), 32'h1);
      check("post_rst_new_pc", pif.new_pc, 32'h0000_1000);
      check("post_rst_timeout", 32'(pif.stall_timeout), 32'h0);
      tick();
      check("post_rst_flush_end", 32'(pif.flush), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencing controller for the six-stage core (PC, IF, ID, EX, MEM, WB). It merges per-stage stall requests into the `stall[5:0]` vector consumed by every inter-stage buffer. It sequences exception and ERET redirects through a flush/settle state machine and accounts stall cycles. It sits beside the stage buffers and drives their `stall` inputs, the pipeline `flush` line and the PC redirect.

## Interface
- `SETTLE_CYCLES`, 2: cycles after a flush during which new redirects are ignored (1..15).
- `STALL_LIMIT`, 1024: consecutive-stall-cycle threshold for the watchdog (2..65535).
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `stallreq_if`  in  1  IF stage (instruction bus) requests a stall.
- `stallreq_id`  in  1  ID stage (load-use) requests a stall.
- `stallreq_ex`  in  1  EX stage (multi-cycle madd/div) requests a stall.
- `stallreq_mem`  in  1  MEM stage (data bus) requests a stall.
- `except_req`  in  1  MEM stage reports an exception this cycle.
- `except_vec`  in  32  handler address accompanying `except_req`.
- `eret_req`  in  1  MEM stage retires ERET this cycle.
- `epc`  in  32  return address accompanying `eret_req`.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- `flush`  out  1  registered; clears all stage buffers to NOP.
- `new_pc`  out  32  registered redirect target; valid while `flush`=1.
- `stall_cycles`  out  32  saturating count of cycles with any `stall` bit set.
- `stall_timeout`  out  1  sticky watchdog flag (see Configuration).

## Operation
- FSM states are RUN, FLUSH and SETTLE. Reset enters RUN.
- Stall vector (combinational, highest requesting stage wins):
  - mem gives 6'b011111.
  - ex gives 6'b001111.
  - id gives 6'b000111.
  - if gives 6'b000011.
  - no request gives 6'b000000.
  - WB is never stalled.
- In FLUSH, `stall` is forced to 0. In RUN and SETTLE it follows the requests.
- RUN: if `except_req` or `eret_req` is sampled high at a rising edge, go to FLUSH.
  - `new_pc` is loaded with `except_vec` for an exception, or `epc` for ERET.
  - `except_req` wins if both are high.
  - A redirect is taken even while stall requests are active.
- FLUSH: `flush`=1 for exactly one cycle, then go to SETTLE.
  - The settle counter is loaded with SETTLE_CYCLES-1.
- SETTLE: the counter decrements each cycle. At 0, go to RUN.
  - `except_req` and `eret_req` are ignored (dropped, not queued) in FLUSH and SETTLE.
- `new_pc` holds its last value outside FLUSH.
- `stall_cycles` increments on each cycle with `stall`≠0 and saturates at 32'hFFFFFFFF.

## Timing
- Reset values: `flush`=0, `new_pc`=0, `stall_cycles`=0, `stall_timeout`=0, FSM in RUN, settle counter 0.
- While `rst`=0, `stall` is forced to 6'b000000.
- Stall latency is 0 cycles: a request in cycle N appears on `stall` in cycle N.
- Redirect latency: a request sampled at edge N gives `flush`/`new_pc` valid from edge N to N+1.
  - The FSM returns to RUN SETTLE_CYCLES cycles after FLUSH ends.
- Reset asserted mid-FLUSH or mid-SETTLE returns to RUN immediately. Any pending redirect is lost.
- A stall request held across FLUSH is masked for that one cycle and reappears in SETTLE.

## Configuration
- `PIPE_CTRL_WDOG_EN` defined:
  - A 16-bit counter counts consecutive cycles with `stall`≠0 and clears on any cycle with `stall`=0.
  - When the counter reaches STALL_LIMIT, `stall_timeout` sets and stays 1 until reset.
  - The counter saturates at STALL_LIMIT.
- `PIPE_CTRL_WDOG_EN` undefined: no counter is built and `stall_timeout` is tied to 0.

## Test plan
- Stall priority:
  - `stallreq_id`=1 alone gives `stall`=6'b000111.
  - Adding `stallreq_mem`=1 gives 6'b011111.
  - Releasing all requests gives 6'b000000 in the same cycle.
- Exception: `except_req`=1 with `except_vec`=32'hBFC00380 for one cycle.
  - Next cycle: `flush`=1, `new_pc`=32'hBFC00380, `stall`=0.
  - With SETTLE_CYCLES=2, RUN is re-entered 2 cycles later.
- Simultaneous redirects: `except_req`=1 and `eret_req`=1 with `epc`=32'h00000040 → `new_pc`=`except_vec`. A second `except_req` during SETTLE produces no `flush`.
- Reset mid-operation: drop `rst` to 0 during SETTLE.
  - `flush`=0 and `stall`=0 immediately.
  - After release, `eret_req` with `epc`=32'h00001000 flushes one cycle later.
- Stall accounting: hold `stallreq_ex`=1 for 10 cycles → `stall_cycles`=10.
- Watchdog (macro defined, STALL_LIMIT=8):
  - Hold `stallreq_mem` for 8 cycles → `stall_timeout`=1 and stays 1 after release.
  - With the macro undefined, `stall_timeout` stays 0.
